font_rom_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous font ROM between the character text pipeline (port 0, pixel-deadline critical) and a secondary requester (port 1, e.g. cursor/overlay glyph preload). It accepts at most one read per clock, drives the ROM address, tracks the read in flight, and returns ROM data to the winning port with a per-port valid strobe. It sits between the data generators and the font ROM, on the same clock as the VGA sync logic.

---
 rtl/font_rom_arbiter_pkg.sv | 19 +
 rtl/font_rom_arbiter_rom_tag_pipe.sv | 32 +++
 rtl/font_rom_arbiter.sv | 131 +++++++++++++
 tb/tb_font_rom_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/font_rom_arbiter_pkg.sv
// Shared font/video definitions for the font ROM arbiter.
// Covers ROM geometry, requester port ids and the in-flight read tag.
package font_rom_arbiter_pkg;

  localparam int FONT_ADDR_W  = 11;
  localparam int FONT_DATA_W  = 8;
  localparam int FONT_ROM_LAT = 1;

  typedef enum logic {
    PORT_TEXT = 1'b0,
    PORT_AUX  = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     valid;
    port_id_e port;
  } rom_tag_t;

endpackage

// File: rtl/font_rom_arbiter_rom_tag_pipe.sv
// Shift register carrying {valid, port id} alongside the font ROM read.
// It is aligned so the output tag meets the ROM data of the same read.
module rom_tag_pipe
  import font_rom_arbiter_pkg::*;
#(
  parameter int DEPTH = FONT_ROM_LAT + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rom_tag_t tag_in,
  output rom_tag_t tag_out
);

  rom_tag_t stage_r [DEPTH];

  // tag shift register; async clear drops every read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-port font ROM arbiter: port 0 is the text pipeline and port 1 is the auxiliary glyph requester.
// Grant order is forced anti-starvation, then port-0 priority, then round-robin.
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = FONT_ADDR_W,
  parameter int DATA_W     = FONT_DATA_W,
  parameter int ROM_LAT    = FONT_ROM_LAT,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prio0,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_dir,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int              CNT_W      = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic            FORCE_EN   = (STARVE_MAX != 0);

  logic [CNT_W-1:0]  starve_cnt_r;
  logic              rr_fav1_r;
  logic [ADDR_W-1:0] rom_dir_r;
  logic              force1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              accept_s;
  logic [ADDR_W-1:0] win_addr_s;
  rom_tag_t          tag_in_s;
  rom_tag_t          tag_out_s;

  // grant selection; the reset gate keeps grants low while reset is held
  always_comb begin
    force1_s = FORCE_EN && req1 && (starve_cnt_r == STARVE_LIM);
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
    if (!reset) begin
      gnt0_s = 1'b0;
    end else if (force1_s) begin
      gnt1_s = 1'b1;
    end else if (prio0 && req0) begin
      gnt0_s = 1'b1;
    end else if (req0 && req1) begin
      gnt1_s = rr_fav1_r;
      gnt0_s = !rr_fav1_r;
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  // winning address and tag for the pipeline
  always_comb begin
    accept_s       = gnt0_s || gnt1_s;
    tag_in_s.valid = accept_s;
    if (gnt1_s) begin
      win_addr_s    = addr1;
      tag_in_s.port = PORT_AUX;
    end else begin
      win_addr_s    = addr0;
      tag_in_s.port = PORT_TEXT;
    end
  end

  // ROM address, round-robin pointer and port-1 starvation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_dir_r    <= '0;
      rr_fav1_r    <= 1'b0;
      starve_cnt_r <= '0;
    end else begin
      if (accept_s) begin
        rom_dir_r <= win_addr_s;
        rr_fav1_r <= gnt0_s;
      end else begin
        rom_dir_r <= rom_dir_r;
        rr_fav1_r <= rr_fav1_r;
      end
      if (req1 && !gnt1_s) begin
        if (starve_cnt_r != STARVE_LIM) begin
          starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
          starve_cnt_r <= starve_cnt_r;
        end
      end else begin
        starve_cnt_r <= '0;
      end
    end
  end

  rom_tag_pipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  // route returning ROM data to the port that owns the read
  always_comb begin
    rvalid0 = tag_out_s.valid && (tag_out_s.port == PORT_TEXT);
    rvalid1 = tag_out_s.valid && (tag_out_s.port == PORT_AUX);
    if (rvalid0) begin
      rdata0 = rom_data;
    end else begin
      rdata0 = '0;
    end
    if (rvalid1) begin
      rdata1 = rom_data;
    end else begin
      rdata1 = '0;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rom_dir = rom_dir_r;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: two instances (STARVE_MAX 15 and 0) share directed and random stimulus.
// Each instance is compared against a rule-level reference model every cycle.
module tb_font_rom_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, prio0, req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          g0 [2];
  logic          g1 [2];
  logic          v0 [2];
  logic          v1 [2];
  logic [DW-1:0] d0 [2];
  logic [DW-1:0] d1 [2];
  logic [AW-1:0] dir [2];
  logic [DW-1:0] rom_q [2];

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  int            smax [2] = '{15, 0};
  int            cnt  [2];
  int            last [2];
  logic [AW-1:0] m_dir [2];
  bit            sv [2][4];
  int            sp [2][4];
  logic [AW-1:0] sa [2][4];

  font_rom_arbiter #(.STARVE_MAX(15)) u_dut_a (
    .clk(clk), .reset(reset), .prio0(prio0), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0[0]), .gnt1(g1[0]),
    .rvalid0(v0[0]), .rvalid1(v1[0]), .rdata0(d0[0]), .rdata1(d1[0]),
    .rom_dir(dir[0]), .rom_data(rom_q[0])
  );

  font_rom_arbiter #(.STARVE_MAX(0)) u_dut_b (
    .clk(clk), .reset(reset), .prio0(prio0), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(g0[1]), .gnt1(g1[1]),
    .rvalid0(v0[1]), .rvalid1(v1[1]), .rdata0(d0[1]), .rdata1(d1[1]),
    .rom_dir(dir[1]), .rom_data(rom_q[1])
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    lo = a[7:0];
    return (lo ^ 8'hA5) + {5'd0, a[10:8]};
  endfunction

  always @(posedge clk) begin
    rom_q[0] <= rom_fn(dir[0]);
    rom_q[1] <= rom_fn(dir[1]);
  end

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s[dut%0d] cycle %0d: observed %0h expected %0h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    cnt[i]   = 0;
    last[i]  = 1;
    m_dir[i] = '0;
    for (int s = 0; s < 4; s++) sv[i][s] = 1'b0;
  endtask

  // check one cycle at the falling edge, then advance the model past the rising edge
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit            e0, e1, ev;
      int            slot;
      logic [AW-1:0] wa;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!reset) begin
        e0 = 1'b0;
      end else if (smax[i] != 0 && req1 && cnt[i] == smax[i]) begin
        e1 = 1'b1;
      end else if (prio0 && req0) begin
        e0 = 1'b1;
      end else if (req0 && req1) begin
        e1 = (last[i] == 0);
        e0 = !e1;
      end else begin
        e0 = req0;
        e1 = req1;
      end
      slot = cyc % 4;
      ev   = reset && sv[i][slot];
      chk("gnt0", i, {31'd0, g0[i]}, {31'd0, e0});
      chk("gnt1", i, {31'd0, g1[i]}, {31'd0, e1});
      chk("rvalid0", i, {31'd0, v0[i]}, {31'd0, ev && sp[i][slot] == 0});
      chk("rvalid1", i, {31'd0, v1[i]}, {31'd0, ev && sp[i][slot] == 1});
      chk("rdata0", i, {24'd0, d0[i]}, (ev && sp[i][slot] == 0) ? {24'd0, rom_fn(sa[i][slot])} : 32'd0);
      chk("rdata1", i, {24'd0, d1[i]}, (ev && sp[i][slot] == 1) ? {24'd0, rom_fn(sa[i][slot])} : 32'd0);
      chk("rom_dir", i, {21'd0, dir[i]}, reset ? {21'd0, m_dir[i]} : 32'd0);
      sv[i][slot] = 1'b0;
      if (!reset) begin
        model_reset(i);
      end else begin
        if (e0 || e1) begin
          wa       = e1 ? addr1 : addr0;
          m_dir[i] = wa;
          last[i]  = e1 ? 1 : 0;
          sv[i][(cyc + 2) % 4] = 1'b1;
          sp[i][(cyc + 2) % 4] = e1 ? 1 : 0;
          sa[i][(cyc + 2) % 4] = wa;
        end
        if (req1 && !e1) begin
          if (cnt[i] < smax[i]) cnt[i]++;
        end else begin
          cnt[i] = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; prio0 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    model_reset(0);
    model_reset(1);
    #1;
    step(); step();
    reset = 1'b1;

    // single port-0 read
    req0 = 1'b1; addr0 = 11'h41F;
    step();
    req0 = 1'b0;
    repeat (3) step();

    // both ports, no priority: alternating grants
    req0 = 1'b1; req1 = 1'b1; addr0 = 11'h010; addr1 = 11'h020;
    repeat (8) step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // port-0 priority with continuous port-1 request: forced grant
    prio0 = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 11'h055; addr1 = 11'h2AA;
    repeat (34) step();
    req0 = 1'b0; req1 = 1'b0; prio0 = 1'b0;
    repeat (3) step();

    // back-to-back port-0 stream
    req0 = 1'b1;
    for (int a = 'h100; a <= 'h107; a++) begin
      addr0 = AW'(a);
      step();
    end
    req0 = 1'b0;
    repeat (3) step();

    // reset lands one cycle after a port-1 accept
    req1 = 1'b1; addr1 = 11'h3FF;
    step();
    req1 = 1'b0; reset = 1'b0;
    step(); step();
    reset = 1'b1;
    repeat (4) step();

    // port-1 drops its request while starved, then re-requests
    prio0 = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 11'h011; addr1 = 11'h622;
    repeat (10) step();
    req1 = 1'b0;
    step();
    req1 = 1'b1;
    repeat (18) step();
    req0 = 1'b0; req1 = 1'b0; prio0 = 1'b0;
    repeat (3) step();

    // randomized traffic with priority phases and rare resets
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 99) != 0);
      prio0 = ((k / 50) % 2) == 1;
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 1) != 0);
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      step();
    end
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
